reel_game_ctrl: RTL and testbench



---
 rtl/reel_game_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_reel_game_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reel_game_ctrl.sv
// -----------------------------------------------------------------------------
// reel_game_ctrl -- slot-machine style reel game controller.
//
// A free-running 32-bit Fibonacci LFSR (taps 32,22,2,1) supplies reel symbols.
// In IDLE the player steps the bet and starts a spin. Each reel then reloads
// its symbol from the LFSR every cycle until its staggered stop point, after
// which a single EVAL cycle scores the line and returns to IDLE. When the credit
// reaches zero the game parks in OVER until a start request restarts it.
//
// Optional feature macro: REEL_GAME_EARLY_STOP_EN
//   defined   -> start_pulse_i during SPIN freezes every reel at once
//   undefined -> start_pulse_i during SPIN is ignored
//
// Ports:
//   clk_i           system clock, all state changes on the rising edge
//   rst_i           synchronous active-high reset
//   start_pulse_i   one-cycle start / restart / early-stop request
//   bet_pulse_i     one-cycle bet-step request
//   sym_o           reel symbols, reel k at [k*SYM_W +: SYM_W]
//   reel_stopped_o  bit k high while reel k is frozen
//   score_o         current credit
//   bet_o           current bet level, 1..MAX_BET
//   state_o         IDLE=0, SPIN=1, EVAL=2, OVER=3
//   done_o          one-cycle pulse when a spin result is settled
//   win_o           high from settlement to next spin start if payout > 0
// -----------------------------------------------------------------------------
module reel_game_ctrl #(
    parameter int unsigned        NUM_REELS      = 5,
    parameter int unsigned        SYM_W          = 3,
    parameter int unsigned        SCORE_W        = 16,
    parameter int unsigned        SPIN_CYCLES    = 16,
    parameter int unsigned        STAGGER_CYCLES = 4,
    parameter logic [SCORE_W-1:0] START_CREDIT   = SCORE_W'(100),
    parameter int unsigned        MAX_BET        = 5,
    parameter logic [31:0]        LFSR_SEED      = 32'hACE1_2468
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_pulse_i,
    input  logic                         bet_pulse_i,
    output logic [NUM_REELS*SYM_W-1:0]   sym_o,
    output logic [NUM_REELS-1:0]         reel_stopped_o,
    output logic [SCORE_W-1:0]           score_o,
    output logic [3:0]                   bet_o,
    output logic [1:0]                   state_o,
    output logic                         done_o,
    output logic                         win_o
);

    localparam int unsigned SYMS_W = NUM_REELS * SYM_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SPIN = 2'd1,
        ST_EVAL = 2'd2,
        ST_OVER = 2'd3
    } state_t;

    state_t               state_q,   state_d;
    logic [31:0]          lfsr_q,    lfsr_d;
    logic [15:0]          cnt_q,     cnt_d;
    logic [SYMS_W-1:0]    sym_q,     sym_d;
    logic [NUM_REELS-1:0] stopped_q, stopped_d;
    logic [SCORE_W-1:0]   score_q,   score_d;
    logic [3:0]           bet_q,     bet_d;
    logic                 done_q,    done_d;
    logic                 win_q,     win_d;

    logic                 lfsr_fb;
    logic                 early_stop;
    logic [SCORE_W-1:0]   bet_ext;
    logic [3:0]           match_cnt;
    logic                 match_run;
    logic [7:0]           payout;
    logic [SCORE_W:0]     score_sum;

    assign lfsr_fb = lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0];
    assign bet_ext = SCORE_W'(bet_q);

`ifdef REEL_GAME_EARLY_STOP_EN
    assign early_stop = start_pulse_i;
`else
    assign early_stop = 1'b0;
`endif

    // Count the unbroken run of reels, from reel 0 upward, showing reel 0's symbol.
    always_comb begin
        match_cnt = '0;
        match_run = 1'b1;
        for (int k = 0; k < NUM_REELS; k++) begin
            if (match_run && (sym_q[k*SYM_W +: SYM_W] == sym_q[SYM_W-1:0])) begin
                match_cnt = match_cnt + 4'd1;
            end else begin
                match_run = 1'b0;
            end
        end
    end

    always_comb begin
        if (match_cnt == 4'(NUM_REELS)) begin
            payout = {1'b0, bet_q, 3'b000};        // bet * 8
        end else if (match_cnt >= 4'd3) begin
            payout = {3'b000, bet_q, 1'b0};        // bet * 2
        end else begin
            payout = '0;
        end
    end

    // One spare bit catches the carry so the credit saturates instead of wrapping.
    assign score_sum = {1'b0, score_q} + (SCORE_W+1)'(payout);

    always_comb begin
        // NOTE: every _d starts as its _q so no branch can leave a value unassigned
        // and infer a latch; the branches below only override what changes.
        state_d   = state_q;
        lfsr_d    = {lfsr_q[30:0], lfsr_fb};
        cnt_d     = cnt_q;
        sym_d     = sym_q;
        stopped_d = stopped_q;
        score_d   = score_q;
        bet_d     = bet_q;
        done_d    = 1'b0;
        win_d     = win_q;

        case (state_q)
            ST_IDLE: begin
                if (score_q == '0) begin
                    state_d = ST_OVER;
                end else if (start_pulse_i && (score_q >= bet_ext)) begin
                    score_d   = score_q - bet_ext;
                    win_d     = 1'b0;
                    stopped_d = '0;
                    cnt_d     = '0;
                    state_d   = ST_SPIN;
                end
                // A start in the same cycle wins: it spends the current bet and
                // the bet step is dropped.
                if (bet_pulse_i && !start_pulse_i) begin
                    bet_d = (bet_q == 4'(MAX_BET)) ? 4'd1 : bet_q + 4'd1;
                end
            end

            ST_SPIN: begin
                cnt_d = cnt_q + 16'd1;
                if (early_stop) begin
                    stopped_d = '1;
                    state_d   = ST_EVAL;
                end else begin
                    for (int k = 0; k < NUM_REELS; k++) begin
                        if (!stopped_q[k]) begin
                            sym_d[k*SYM_W +: SYM_W] = lfsr_q[k*SYM_W +: SYM_W];
                            if (cnt_q == 16'(SPIN_CYCLES - 1 + k * STAGGER_CYCLES)) begin
                                stopped_d[k] = 1'b1;
                            end
                        end
                    end
                    if (&stopped_d) begin
                        state_d = ST_EVAL;
                    end
                end
            end

            ST_EVAL: begin
                score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                done_d  = 1'b1;
                win_d   = (payout != '0);
                state_d = ST_IDLE;
            end

            ST_OVER: begin
                if (start_pulse_i) begin
                    score_d = START_CREDIT;
                    bet_d   = 4'd1;
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Reset is sampled on the clock edge and overrides every request, so a spin
    // cut short by reset never reaches EVAL and never pays out.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state is assigned with <= so every register samples the
        // pre-edge values, independent of statement order.
        if (rst_i) begin
            state_q   <= ST_IDLE;
            lfsr_q    <= LFSR_SEED;
            cnt_q     <= '0;
            sym_q     <= '0;
            stopped_q <= '1;
            score_q   <= START_CREDIT;
            bet_q     <= 4'd1;
            done_q    <= 1'b0;
            win_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            cnt_q     <= cnt_d;
            sym_q     <= sym_d;
            stopped_q <= stopped_d;
            score_q   <= score_d;
            bet_q     <= bet_d;
            done_q    <= done_d;
            win_q     <= win_d;
        end
    end

    assign sym_o          = sym_q;
    assign reel_stopped_o = stopped_q;
    assign score_o        = score_q;
    assign bet_o          = bet_q;
    assign state_o        = state_q;
    assign done_o         = done_q;
    assign win_o          = win_q;

endmodule

// File: tb/tb_reel_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_reel_game_ctrl -- self-checking bench for reel_game_ctrl (default
// parameters). A reference LFSR tracks the DUT's random source so the bench can
// choose start cycles that yield a wanted match count and predict the stopped
// symbols; expected results are queued at spin start and compared at done_o.
// A second instance preloaded with 65530 credit exercises score saturation.
// Honours REEL_GAME_EARLY_STOP_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_reel_game_ctrl;

    localparam int          N     = 5;
    localparam int          SW    = 3;
    localparam int          SPIN  = 16;
    localparam int          STAG  = 4;
    localparam logic [31:0] SEED  = 32'hACE1_2468;
    localparam logic [1:0]  S_IDLE = 2'd0, S_SPIN = 2'd1, S_EVAL = 2'd2, S_OVER = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, bet = 1'b0;
    logic start2 = 1'b0, bet2 = 1'b0;

    logic [N*SW-1:0] sym,     sym_s;
    logic [N-1:0]    stopped, stopped_s;
    logic [15:0]     score,   score_s;
    logic [3:0]      bet_lvl, bet_s;
    logic [1:0]      state,   state_s;
    logic            done,    done_s;
    logic            win,     win_s;

    always #5 clk = ~clk;

    reel_game_ctrl dut (
        .clk_i(clk), .rst_i(rst), .start_pulse_i(start), .bet_pulse_i(bet),
        .sym_o(sym), .reel_stopped_o(stopped), .score_o(score), .bet_o(bet_lvl),
        .state_o(state), .done_o(done), .win_o(win)
    );

    reel_game_ctrl #(.START_CREDIT(16'd65530)) dut_sat (
        .clk_i(clk), .rst_i(rst), .start_pulse_i(start2), .bet_pulse_i(bet2),
        .sym_o(sym_s), .reel_stopped_o(stopped_s), .score_o(score_s), .bet_o(bet_s),
        .state_o(state_s), .done_o(done_s), .win_o(win_s)
    );

    // Reference random source, shared by both instances (common reset).
    logic [31:0] m_lfsr;

    function automatic logic [31:0] step(input logic [31:0] x);
        return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
    endfunction

    always @(posedge clk) begin
        if (rst) m_lfsr <= SEED;
        else     m_lfsr <= step(m_lfsr);
    end

    // Symbols left on the reels by a start sampled while the LFSR holds v.
    function automatic logic [N*SW-1:0] predict(input logic [31:0] v);
        logic [31:0]     x;
        logic [N*SW-1:0] s;
        x = v;
        s = '0;
        for (int c = 0; c < SPIN + (N - 1) * STAG; c++) begin
            x = step(x);
            for (int k = 0; k < N; k++) begin
                if (c == SPIN - 1 + k * STAG) s[k*SW +: SW] = x[k*SW +: SW];
            end
        end
        return s;
    endfunction

    function automatic int match_of(input logic [N*SW-1:0] s);
        int m;
        bit run;
        m   = 0;
        run = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (run && s[k*SW +: SW] == s[SW-1:0]) m++;
            else run = 1'b0;
        end
        return m;
    endfunction

    function automatic int pay_of(input int m, input int b);
        if (m == N) return b * 8;
        if (m >= 3) return b * 2;
        return 0;
    endfunction

    // want < 0: anything; want == 0: a losing line; otherwise that exact match count.
    function automatic bit want_ok(input int m, input int want);
        if (want < 0)  return 1'b1;
        if (want == 0) return (m < 3);
        return (m == want);
    endfunction

    function automatic int find(input logic [31:0] v, input int want);
        logic [31:0] x;
        x = v;
        for (int d = 0; d < 60000; d++) begin
            if (want_ok(match_of(predict(x)), want)) return d;
            x = step(x);
        end
        return -1;
    endfunction

    typedef struct {
        logic [N*SW-1:0] sym;
        int              score;
        bit              win;
    } exp_t;

    exp_t            sb[$];
    int              score_m, bet_m;
    logic [N*SW-1:0] last_sym;
    int              n_tests = 0;
    int              n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_bets(input bit m, input bit s);
        bet  = m;
        bet2 = s;
        tick(1);
        bet  = 1'b0;
        bet2 = 1'b0;
        if (m) bet_m = (bet_m == 5) ? 1 : bet_m + 1;
    endtask

    task automatic push_expect(input logic [N*SW-1:0] s);
        exp_t e;
        int   p;
        p       = pay_of(match_of(s), bet_m);
        score_m = score_m - bet_m + p;
        if (score_m > 65535) score_m = 65535;
        e.sym    = s;
        e.score  = score_m;
        e.win    = (p > 0);
        last_sym = s;
        sb.push_back(e);
    endtask

    // Wait for a start cycle giving the wanted outcome, then fire the start.
    task automatic launch(input int want, input bit with_sat, input bit with_bet);
        int d;
        d = find(m_lfsr, want);
        check("search", (d >= 0), 1);
        if (d < 0) d = 0;
        tick(d);
        push_expect(predict(m_lfsr));
        start  = 1'b1;
        start2 = with_sat;
        bet    = with_bet;
        tick(1);
        start  = 1'b0;
        start2 = 1'b0;
        bet    = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        exp_t e;
        int   i;
        i = 0;
        while (!done && i < 100) begin
            tick(1);
            i++;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_sb"}, (sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_sym"},   sym,   e.sym);
            check({tag, "_score"}, score, e.score);
            check({tag, "_win"},   win,   e.win);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_state"},   state,   S_IDLE);
        check({tag, "_score"},   score,   100);
        check({tag, "_bet"},     bet_lvl, 1);
        check({tag, "_sym"},     sym,     0);
        check({tag, "_stopped"}, stopped, 5'h1f);
        check({tag, "_done"},    done,    0);
        check({tag, "_win"},     win,     0);
    endtask

    int              exp_bet[7] = '{2, 3, 4, 5, 1, 2, 3};
    int              seen;
    logic [31:0]     v, x;

    initial begin
        // Reset and power-on values.
        tick(3);
        check_reset("reset");
        check("sat_reset_score", score_s, 65530);
        rst     = 1'b0;
        score_m = 100;
        bet_m   = 1;

        // Bet stepping wraps MAX_BET back to 1 and never touches the credit.
        for (int i = 0; i < 7; i++) begin
            pulse_bets(1'b1, 1'b0);
            check("bet_step", bet_lvl, exp_bet[i]);
            check("bet_score", score, 100);
        end

        // Spin timing at bet 3: start cycle T, now at T+1.
        launch(-1, 1'b0, 1'b0);
        check("t1_score",   score,   97);
        check("t1_state",   state,   S_SPIN);
        check("t1_stopped", stopped, 0);
        tick(15);
        check("t16_stop0", stopped[0], 0);
        tick(1);
        check("t17_stop0", stopped[0], 1);
        check("t17_state", state, S_SPIN);
        tick(15);
        check("t32_stop4", stopped[4], 0);
        tick(1);
        check("t33_stopped", stopped, 5'h1f);
        check("t33_state",   state,   S_EVAL);
        check("t33_done",    done,    0);
        tick(1);
        check("t34_state", state, S_IDLE);
        wait_done("timing");
        tick(1);
        check("done_one_cycle", done, 0);

        // Jackpot at bet 5 on both instances; the preloaded one saturates.
        pulse_bets(1'b1, 1'b1);
        pulse_bets(1'b1, 1'b1);
        pulse_bets(1'b0, 1'b1);
        pulse_bets(1'b0, 1'b1);
        check("bet5", bet_lvl, 5);
        check("sat_bet5", bet_s, 5);
        launch(5, 1'b1, 1'b0);
        wait_done("jackpot");
        check("jackpot_win", win, 1);
        check("sat_done",  done_s,  1);
        check("sat_score", score_s, 65535);
        check("sat_win",   win_s,   1);
        check("sat_sym",   sym_s,   last_sym);
        check("sat_state", state_s, S_IDLE);
        check("sat_stopped", stopped_s, 5'h1f);

        // Three-match, with a bet pulse in the start cycle that must be dropped.
        launch(3, 1'b0, 1'b1);
        check("same_cycle_bet", bet_lvl, 5);
        wait_done("match3");
        check("match3_win", win, 1);

        // Two-match pays nothing; the start clears the previous win.
        launch(2, 1'b0, 1'b0);
        check("win_cleared", win, 0);
        wait_done("match2");
        check("match2_win", win, 0);

        // Start request at spin counter 5.
        v = m_lfsr;
`ifdef REEL_GAME_EARLY_STOP_EN
        x = v;
        repeat (5) x = step(x);
        push_expect(x[N*SW-1:0]);
`else
        push_expect(predict(v));
`endif
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(5);
        start = 1'b1;
        tick(1);
        start = 1'b0;
`ifdef REEL_GAME_EARLY_STOP_EN
        check("early_stopped", stopped, 5'h1f);
        check("early_state",   state,   S_EVAL);
`else
        check("early_ignored_stopped", stopped, 0);
        check("early_ignored_state",   state,   S_SPIN);
`endif
        wait_done("early");

        // Reset at spin counter 10: everything back to reset values, no payout.
        launch(-1, 1'b0, 1'b0);
        tick(10);
        rst = 1'b1;
        tick(1);
        check_reset("midspin_rst");
        rst = 1'b0;
        sb.delete();
        score_m = 100;
        bet_m   = 1;
        seen    = 0;
        repeat (40) begin
            tick(1);
            if (done) seen++;
        end
        check("no_done_after_rst", seen, 0);
        check("after_rst_score", score, 100);

        // Drain the credit with losing spins.
        repeat (4) pulse_bets(1'b1, 1'b0);
        repeat (19) begin
            launch(0, 1'b0, 1'b0);
            wait_done("drain");
        end
        check("drain_score5", score, 5);
        repeat (3) pulse_bets(1'b1, 1'b0);
        launch(0, 1'b0, 1'b0);
        wait_done("drain_b3");
        check("drain_score2", score, 2);

        // Credit 2 < bet 3: start ignored.
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("low_credit_state",   state,   S_IDLE);
        check("low_credit_score",   score,   2);
        check("low_credit_stopped", stopped, 5'h1f);

        // Spend the last credit at bet 2, then OVER and restart.
        repeat (4) pulse_bets(1'b1, 1'b0);
        check("bet2", bet_lvl, 2);
        launch(0, 1'b0, 1'b0);
        wait_done("drain_last");
        check("score_zero", score, 0);
        tick(1);
        check("over_state", state, S_OVER);
        pulse_bets(1'b1, 1'b0);
        check("over_bet_ignored", bet_lvl, 2);
        check("over_hold", state, S_OVER);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("restart_score", score, 100);
        check("restart_bet",   bet_lvl, 1);
        check("restart_state", state, S_IDLE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #990000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
